// File: rtl/normalize_pipe.sv
`default_nettype none
// ============================================================================
// normalize_pipe : two-stage leading-zero normalizer with valid/ready on both
//                  sides; reports the shift so the exponent can be adjusted.
// Revision 1.0
// ============================================================================

module normalize_lzc #(
  parameter int WIDTH           = 32,
  parameter int SHIFT_VAL_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]           data,
  output logic [SHIFT_VAL_WIDTH-1:0] count
);
  // Scanning upward lets the highest set bit win without a found flag.
  always_comb begin
    count = SHIFT_VAL_WIDTH'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = SHIFT_VAL_WIDTH'(WIDTH - 1 - i);
    end
  end
endmodule

module normalize_shift #(
  parameter int WIDTH           = 32,
  parameter int SHIFT_VAL_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]           data,
  input  logic [SHIFT_VAL_WIDTH-1:0] shift,
  output logic [WIDTH-1:0]           result
);
  assign result = data << shift;
endmodule

module normalize_pipe #(
  parameter int WIDTH           = 32,
  parameter int SHIFT_VAL_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [SHIFT_VAL_WIDTH-1:0] out_shift,
  output logic                       out_zero
);
  logic                       s1_valid;
  logic [WIDTH-1:0]           s1_data;
  logic [SHIFT_VAL_WIDTH-1:0] s1_lzc;
  logic                       s2_valid;
  logic                       s1_adv;
  logic                       s2_adv;
  logic [SHIFT_VAL_WIDTH-1:0] in_lzc;
  logic [WIDTH-1:0]           s1_shifted;

  normalize_lzc #(
    .WIDTH           (WIDTH),
    .SHIFT_VAL_WIDTH (SHIFT_VAL_WIDTH)
  ) u_lzc (
    .data  (in_data),
    .count (in_lzc)
  );

  normalize_shift #(
    .WIDTH           (WIDTH),
    .SHIFT_VAL_WIDTH (SHIFT_VAL_WIDTH)
  ) u_shift (
    .data   (s1_data),
    .shift  (s1_lzc),
    .result (s1_shifted)
  );

  // Ready ripples back combinationally so a full pipe can accept and drain together.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_lzc    <= '0;
      s2_valid  <= 1'b0;
      out_data  <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data  <= s1_shifted;
          out_shift <= s1_lzc;
          out_zero  <= (s1_lzc == SHIFT_VAL_WIDTH'(WIDTH));
        end
      end
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= in_data;
          s1_lzc  <= in_lzc;
        end
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_normalize_pipe.sv
`default_nettype none
// ============================================================================
// tb_normalize_pipe : directed and randomized self-checking bench for
//                     normalize_pipe (WIDTH = 32).
// Revision 1.0
// ============================================================================

module tb_normalize_pipe;
  localparam int W  = 32;
  localparam int SW = 6;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_shift;
  logic          out_zero;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] shift;
  } exp_t;

  exp_t exp_q[$];

  logic [W-1:0]  tbl_in   [10];
  logic [W-1:0]  tbl_data [10];
  logic [SW-1:0] tbl_shift[10];

  normalize_pipe #(.WIDTH(W), .SHIFT_VAL_WIDTH(SW)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_zero  (out_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] d, input logic [SW-1:0] s, input logic z);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".data"},  64'(out_data),  64'(d));
    chk({tag, ".shift"}, 64'(out_shift), 64'(s));
    chk({tag, ".zero"},  64'(out_zero),  64'(z));
  endtask

  // Independent reference: shift left one bit at a time until the MSB is set.
  function automatic exp_t ref_norm(input logic [W-1:0] v);
    exp_t r;
    r.data  = v;
    r.shift = '0;
    if (v == '0) begin
      r.shift = SW'(W);
    end else begin
      while (!r.data[W-1]) begin
        r.data  = r.data << 1;
        r.shift = r.shift + 1'b1;
      end
    end
    return r;
  endfunction

  // Streams n beats; in_valid held high and out_ready low in [st_lo, st_hi] unless rnd.
  task automatic run_stream(input string tag, input int n, input int st_lo, input int st_hi, input bit rnd);
    int sent = 0;
    int got  = 0;
    int c    = 0;
    int blocked = 0;
    logic [W-1:0]  held_d = '0;
    logic [SW-1:0] held_s = '0;
    logic [W-1:0]  v;
    exp_t e;
    while (got < n && c < 20 * n + 100) begin
      v = rnd ? ($urandom() >> $urandom_range(0, 32)) : tbl_in[sent % 10];
      in_valid  = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_data   = in_valid ? v : $urandom();
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(c >= st_lo && c <= st_hi);
      #1;
      if (!rnd && c == st_lo) begin
        held_d = out_data;
        held_s = out_shift;
        chk({tag, ".stall_valid"}, 64'(out_valid), 64'd1);
      end
      if (!rnd && c > st_lo && c <= st_hi) begin
        chk({tag, ".stall_data"},  64'(out_data),  64'(held_d));
        chk({tag, ".stall_shift"}, 64'(out_shift), 64'(held_s));
        chk({tag, ".stall_ready"}, 64'(in_ready),  64'd0);
      end
      if (in_valid && !in_ready && out_ready) blocked++;
      if (in_valid && in_ready) begin
        if (rnd) e = ref_norm(v);
        else begin
          e.data  = tbl_data[sent % 10];
          e.shift = tbl_shift[sent % 10];
        end
        exp_q.push_back(e);
        sent++;
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk({tag, ".data"},  64'(out_data),  64'(e.data));
        chk({tag, ".shift"}, 64'(out_shift), 64'(e.shift));
        chk({tag, ".zero"},  64'(out_zero),  64'(e.shift == SW'(W)));
        got++;
      end
      @(posedge clock);
      #1;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, ".count"}, 64'(got), 64'(n));
    chk({tag, ".no_backpressure_when_ready"}, 64'(blocked), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    tbl_in[0] = 32'h0000_0001; tbl_data[0] = 32'h8000_0000; tbl_shift[0] = 6'd31;
    tbl_in[1] = 32'h0000_0003; tbl_data[1] = 32'hC000_0000; tbl_shift[1] = 6'd30;
    tbl_in[2] = 32'h1234_5678; tbl_data[2] = 32'h91A2_B3C0; tbl_shift[2] = 6'd3;
    tbl_in[3] = 32'hFFFF_FFFF; tbl_data[3] = 32'hFFFF_FFFF; tbl_shift[3] = 6'd0;
    tbl_in[4] = 32'h0000_0000; tbl_data[4] = 32'h0000_0000; tbl_shift[4] = 6'd32;
    tbl_in[5] = 32'h0000_FFFF; tbl_data[5] = 32'hFFFF_0000; tbl_shift[5] = 6'd16;
    tbl_in[6] = 32'h4000_0000; tbl_data[6] = 32'h8000_0000; tbl_shift[6] = 6'd1;
    tbl_in[7] = 32'h00AB_CDEF; tbl_data[7] = 32'hABCD_EF00; tbl_shift[7] = 6'd8;
    tbl_in[8] = 32'h0000_0100; tbl_data[8] = 32'h8000_0000; tbl_shift[8] = 6'd23;
    tbl_in[9] = 32'h7FFF_FFFF; tbl_data[9] = 32'hFFFF_FFFE; tbl_shift[9] = 6'd1;

    // Reset state
    cycle();
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_data",  64'(out_data),  64'd0);
    chk("rst.out_shift", 64'(out_shift), 64'd0);
    chk("rst.out_zero",  64'(out_zero),  64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    resetn = 1'b1;
    cycle();

    // Single beat: two-cycle latency, one-cycle valid pulse
    in_valid = 1'b1; in_data = 32'h0000_0001;
    cycle();
    in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
    chk("single.lat1_valid", 64'(out_valid), 64'd0);
    cycle();
    chk_out("single", 32'h8000_0000, 6'd31, 1'b0);
    cycle();
    chk("single.pulse_end", 64'(out_valid), 64'd0);

    // Three back-to-back beats
    in_valid = 1'b1; in_data = 32'h8000_0000;
    cycle();
    in_data = 32'h00F0_0000;
    cycle();
    chk_out("b2b0", 32'h8000_0000, 6'd0, 1'b0);
    in_data = 32'h0000_0000;
    cycle();
    chk_out("b2b1", 32'hF000_0000, 6'd8, 1'b0);
    in_valid = 1'b0;
    cycle();
    chk_out("b2b2", 32'h0000_0000, 6'd32, 1'b1);
    cycle();
    chk("b2b.drained", 64'(out_valid), 64'd0);

    // 10-beat stream with stall, then full-rate stream
    run_stream("stall", 10, 4, 6, 1'b0);
    cycle();
    run_stream("full", 10, -1, -2, 1'b0);
    cycle();

    // Reset while both stages hold beats
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0F00;
    cycle();
    cycle();
    in_valid = 1'b0;
    chk("mid.full_valid", 64'(out_valid), 64'd1);
    chk("mid.full_ready", 64'(in_ready),  64'd0);
    resetn = 1'b0;
    #1;
    chk("mid.async_drop", 64'(out_valid), 64'd0);
    cycle();
    resetn = 1'b1; out_ready = 1'b1;
    cycle();
    cycle();
    cycle();
    chk("mid.no_stale", 64'(out_valid), 64'd0);
    in_valid = 1'b1; in_data = 32'h0001_0000;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk_out("post_rst", 32'h8000_0000, 6'd15, 1'b0);
    cycle();

    // Random traffic against the reference model
    run_stream("rand", 10000, -1, -2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/normalize_pipe.md
Name: normalize_pipe

Overview:
- Two-stage pipelined normalizer for unsigned fixed-point accumulator magnitudes, used ahead of rounding/packing in the float and log-float output paths.
- Counts leading zeros, left-shifts the value so its MSB is 1, and reports the shift amount so the downstream stage can adjust the exponent.
- Valid/ready elastic interface on both sides; sustains one result per cycle.

Parameters:
- WIDTH, 32, bit width of the input and normalized output.
- SHIFT_VAL_WIDTH, $clog2(WIDTH+1), width of the shift count; must hold values 0..WIDTH.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is presented.
- in_ready  output  1  the block accepts in_data this cycle.
- in_data  input  WIDTH  unsigned value to normalize.
- out_valid  output  1  the out_* fields hold a result.
- out_ready  input  1  downstream accepts the result this cycle.
- out_data  output  WIDTH  in_data << out_shift; MSB is 1 unless out_zero.
- out_shift  output  SHIFT_VAL_WIDTH  leading-zero count of in_data; WIDTH when in_data == 0.
- out_zero  output  1  in_data was zero.

Behaviour:
- Reset (asynchronous assert, synchronous-release safe): s1_valid=0, s2_valid=0, all data registers 0. Outputs in reset: out_valid=0, out_data=0, out_shift=0, out_zero=0, in_ready=1.
- Stage 1 register: on accept (in_valid && in_ready), captures in_data and its leading-zero count lzc. lzc is the number of consecutive zeros from bit WIDTH-1 downward, and is WIDTH for all-zero input.
- Stage 2 register: captures s1_data << s1_lzc, s1_lzc, and the flag (s1_lzc == WIDTH). These registers drive out_data, out_shift and out_zero directly.
- Handshake:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv. This is a combinational path from out_ready to in_ready, and it is intended.
- Stage 2 loads when s2_adv is true. s2_valid <= s1_valid at that point; stage-2 data loads only if s1_valid.
- Stage 1 loads when s1_adv is true. s1_valid <= in_valid at that point; stage-1 data loads only if in_valid.
- Latency: a beat accepted in cycle N appears with out_valid=1 in cycle N+2 when not stalled. Throughput is 1 beat/cycle when out_ready is held high.
- Stall: while out_valid && !out_ready, all out_* hold stable. Stage 1 still fills if it is empty. When both stages are full, in_ready=0.
- Simultaneous events:
  - Accept at input and drain at output in the same cycle is legal when full; no bubble is inserted.
  - in_data is ignored when in_valid=0.
- Ordering: beats exit strictly in acceptance order. No beat is dropped or duplicated.
- Zero input: out_data=0, out_shift=WIDTH, out_zero=1.
- Arithmetic: the shift is logical (zero fill). A shift by WIDTH yields 0. Bits shifted out are always zeros by construction.
- Reset mid-operation: in-flight beats are discarded, and out_valid drops asynchronously on resetn low.
- The leading-zero counter and the shifter are instantiated as separate submodules so resource usage can be traced per function.

Test Plan:
- Single beat, WIDTH=32, in_data=0x0000_0001, out_ready=1 -> two cycles later: out_data=0x8000_0000, out_shift=31, out_zero=0; out_valid high for exactly one cycle.
- Three beats back-to-back: 0x8000_0000, 0x00F0_0000, 0x0000_0000 -> results in that order:
  - (0x8000_0000, 0, 0)
  - (0xF000_0000, 8, 0)
  - (0x0000_0000, 32, 1)
- Stream of 10 beats with out_ready low for cycles 4-6 -> in_ready falls once both stages are full; out_* hold stable during the stall; all 10 results arrive in order with no loss or duplication.
- Full pipeline with in_valid=1 and out_ready=1 in the same cycle -> one accept and one drain per cycle; throughput stays 1/cycle.
- resetn pulsed low while both stages are valid -> out_valid=0 immediately; no stale beat emerges after release; the next accepted beat 0x0001_0000 gives out_shift=15 and out_data=0x8000_0000.
- 10k random beats with random in_valid and out_ready -> every result matches the reference model: lzc, in << lzc, (in == 0).
